// File: rtl/ahbl_single_master.sv
`default_nettype none
// ============================================================================
//  Module      : ahbl_single_master
//  Description : AHB-Lite initiator. Turns single-beat local commands into
//                one non-overlapped bus transfer at a time. Responses return
//                on a valid/ready channel.
//  Revision    : 1.0 - initial release
// ============================================================================
module ahbl_single_master #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    // command channel
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_write,
    input  logic [AW-1:0] cmd_addr,
    input  logic [2:0]    cmd_size,
    input  logic [DW-1:0] cmd_wdata,
    // response channel
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic          rsp_err,
    output logic [DW-1:0] rsp_rdata,
    // AHB-Lite master port
    output logic [AW-1:0] HADDR,
    output logic [1:0]    HTRANS,
    output logic          HWRITE,
    output logic [2:0]    HSIZE,
    output logic [2:0]    HBURST,
    output logic [3:0]    HPROT,
    output logic          HMASTLOCK,
    output logic [DW-1:0] HWDATA,
    input  logic [DW-1:0] HRDATA,
    input  logic          HREADY,
    input  logic          HRESP
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ADDR = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;
    localparam logic [1:0] ST_RESP = 2'd3;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    // Largest HSIZE the data bus can carry: 4 bytes on 32-bit, 8 on 64-bit.
    localparam logic [2:0] MAX_SIZE = (DW == 64) ? 3'd3 : 3'd2;

    logic [1:0]    state_q, state_d;
    logic          write_q;
    logic [AW-1:0] addr_q;
    logic [2:0]    size_q;
    logic [DW-1:0] wdata_q;
    logic          err_q;
    logic [DW-1:0] rdata_q;

    logic          cmd_aligned;
    logic          cmd_legal;
    logic          cmd_accept;

    assign cmd_accept = cmd_valid && (state_q == ST_IDLE);

    // Command legality: size must fit the bus and address must be size-aligned.
    always_comb begin
        cmd_aligned = 1'b0;
        case (cmd_size)
            3'd0:    cmd_aligned = 1'b1;
            3'd1:    cmd_aligned = (cmd_addr[0] == 1'b0);
            3'd2:    cmd_aligned = (cmd_addr[1:0] == 2'b00);
            3'd3:    cmd_aligned = (cmd_addr[2:0] == 3'b000);
            default: cmd_aligned = 1'b0;
        endcase
        cmd_legal = cmd_aligned && (cmd_size <= MAX_SIZE);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; rejected commands skip the bus entirely.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (cmd_valid) state_d = cmd_legal ? ST_ADDR : ST_RESP;
            ST_ADDR: if (HREADY)    state_d = ST_DATA;
            ST_DATA: if (HREADY)    state_d = ST_RESP;
            ST_RESP: if (rsp_ready) state_d = ST_IDLE;
            default:                state_d = ST_IDLE;
        endcase
    end

    // Command capture at acceptance and response capture at end of data phase.
    always_ff @(posedge clk) begin
        if (rst) begin
            write_q <= 1'b0;
            addr_q  <= '0;
            size_q  <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            if (cmd_accept) begin
                write_q <= cmd_write;
                addr_q  <= cmd_addr;
                size_q  <= cmd_size;
                wdata_q <= cmd_wdata;
                err_q   <= !cmd_legal;
                rdata_q <= '0;
            end else if ((state_q == ST_DATA) && HREADY) begin
                err_q   <= HRESP;
                rdata_q <= (!write_q && !HRESP) ? HRDATA : '0;
            end
        end
    end

    // State-decoded outputs; nothing here looks at HREADY or HRESP.
    always_comb begin
        cmd_ready = (state_q == ST_IDLE);
        rsp_valid = (state_q == ST_RESP);
        rsp_err   = err_q;
        rsp_rdata = rdata_q;
        HTRANS    = (state_q == ST_ADDR) ? HTRANS_NONSEQ : HTRANS_IDLE;
        HADDR     = addr_q;
        HWRITE    = write_q;
        HSIZE     = size_q;
        HWDATA    = ((state_q == ST_DATA) && write_q) ? wdata_q : '0;
        HBURST    = 3'b000;
        HPROT     = 4'b0011;
        HMASTLOCK = 1'b0;
    end

endmodule
`default_nettype wire
